// File: rtl/idu_queue_pkg.sv
// Shared widths, opcodes and decoded-field encodings for the IDU queue and its decoder.
// INST_SET_RV32M is only produced by idu_dec when IDU_RV32M_EN is defined.
package idu_queue_pkg;

   localparam int unsigned DATA_BUS_WIDTH  = 32;
   localparam int unsigned REG_BUS_WIDTH   = 5;
   localparam int unsigned CSR_BUS_WIDTH   = 12;
   localparam int unsigned INST_SET_WIDTH  = 2;
   localparam int unsigned INST_TYPE_WIDTH = 3;
   localparam int unsigned INST_FUNC_WIDTH = 6;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [INST_SET_WIDTH-1:0] {
      INST_SET_NULL  = 2'd0,
      INST_SET_RV32I = 2'd1,
      INST_SET_RV32M = 2'd2,
      INST_SET_ZICSR = 2'd3
   } inst_set_e;

   typedef enum logic [INST_TYPE_WIDTH-1:0] {
      INST_TYPE_NULL = 3'd0,
      INST_TYPE_R    = 3'd1,
      INST_TYPE_I    = 3'd2,
      INST_TYPE_S    = 3'd3,
      INST_TYPE_B    = 3'd4,
      INST_TYPE_U    = 3'd5,
      INST_TYPE_J    = 3'd6,
      INST_TYPE_CSR  = 3'd7
   } inst_type_e;

   typedef enum logic [INST_FUNC_WIDTH-1:0] {
      INST_FUNC_NULL = 6'd0,
      INST_FUNC_LUI, INST_FUNC_AUIPC, INST_FUNC_JAL, INST_FUNC_JALR,
      INST_FUNC_BEQ, INST_FUNC_BNE, INST_FUNC_BLT, INST_FUNC_BGE, INST_FUNC_BLTU, INST_FUNC_BGEU,
      INST_FUNC_LB, INST_FUNC_LH, INST_FUNC_LW, INST_FUNC_LBU, INST_FUNC_LHU,
      INST_FUNC_SB, INST_FUNC_SH, INST_FUNC_SW,
      INST_FUNC_ADDI, INST_FUNC_SLTI, INST_FUNC_SLTIU, INST_FUNC_XORI, INST_FUNC_ORI,
      INST_FUNC_ANDI, INST_FUNC_SLLI, INST_FUNC_SRLI, INST_FUNC_SRAI,
      INST_FUNC_ADD, INST_FUNC_SUB, INST_FUNC_SLL, INST_FUNC_SLT, INST_FUNC_SLTU,
      INST_FUNC_XOR, INST_FUNC_SRL, INST_FUNC_SRA, INST_FUNC_OR, INST_FUNC_AND,
      INST_FUNC_FENCE,
      INST_FUNC_ECALL, INST_FUNC_EBREAK, INST_FUNC_MRET, INST_FUNC_WFI,
      INST_FUNC_CSRRW, INST_FUNC_CSRRS, INST_FUNC_CSRRC,
      INST_FUNC_CSRRWI, INST_FUNC_CSRRSI, INST_FUNC_CSRRCI,
      INST_FUNC_MUL, INST_FUNC_MULH, INST_FUNC_MULHSU, INST_FUNC_MULHU,
      INST_FUNC_DIV, INST_FUNC_DIVU, INST_FUNC_REM, INST_FUNC_REMU
   } inst_func_e;

   typedef struct packed {
      logic [INST_SET_WIDTH-1:0]  inst_set;
      logic [INST_TYPE_WIDTH-1:0] inst_type;
      logic [INST_FUNC_WIDTH-1:0] inst_func;
      logic [REG_BUS_WIDTH-1:0]   reg1_raddr;
      logic [REG_BUS_WIDTH-1:0]   reg2_raddr;
      logic [REG_BUS_WIDTH-1:0]   reg_waddr;
      logic                       reg_waddr_vld;
      logic [DATA_BUS_WIDTH-1:0]  imm;
      logic [CSR_BUS_WIDTH-1:0]   csr;
      logic                       illegal;
   } dec_t;

endpackage

// File: rtl/idu_dec.sv
// Combinational RV32I/Zicsr instruction decoder; illegal encodings decode to all-zero fields.
// RV32M decoding is compiled in only when IDU_RV32M_EN is defined.
module idu_dec
   import idu_queue_pkg::*;
(
   input  logic [DATA_BUS_WIDTH-1:0] inst_i,
   output dec_t                      dec_o
);

   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic [4:0] rd;
   logic [4:0] rs1;
   logic [4:0] rs2;
   logic [DATA_BUS_WIDTH-1:0] imm_i;
   logic [DATA_BUS_WIDTH-1:0] imm_s;
   logic [DATA_BUS_WIDTH-1:0] imm_b;
   logic [DATA_BUS_WIDTH-1:0] imm_u;
   logic [DATA_BUS_WIDTH-1:0] imm_j;
   dec_t d;
   logic ill;

   assign opcode = inst_i[6:0];
   assign rd     = inst_i[11:7];
   assign func3  = inst_i[14:12];
   assign rs1    = inst_i[19:15];
   assign rs2    = inst_i[24:20];
   assign func7  = inst_i[31:25];

   assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u = {inst_i[31:12], 12'b0};
   assign imm_j = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   always_comb begin
      d          = '0;
      ill        = 1'b0;
      d.inst_set = INST_SET_RV32I;
      unique case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            d.inst_type     = INST_TYPE_U;
            d.inst_func     = (opcode == OPC_LUI) ? INST_FUNC_LUI : INST_FUNC_AUIPC;
            d.reg_waddr     = rd;
            d.reg_waddr_vld = 1'b1;
            d.imm           = imm_u;
         end
         OPC_JAL: begin
            d.inst_type     = INST_TYPE_J;
            d.inst_func     = INST_FUNC_JAL;
            d.reg_waddr     = rd;
            d.reg_waddr_vld = 1'b1;
            d.imm           = imm_j;
         end
         OPC_JALR: begin
            d.inst_type     = INST_TYPE_I;
            d.inst_func     = INST_FUNC_JALR;
            d.reg1_raddr    = rs1;
            d.reg_waddr     = rd;
            d.reg_waddr_vld = 1'b1;
            d.imm           = imm_i;
            ill             = (func3 != 3'd0);
         end
         OPC_BRANCH: begin
            d.inst_type  = INST_TYPE_B;
            d.reg1_raddr = rs1;
            d.reg2_raddr = rs2;
            d.imm        = imm_b;
            case (func3)
               3'd0:    d.inst_func = INST_FUNC_BEQ;
               3'd1:    d.inst_func = INST_FUNC_BNE;
               3'd4:    d.inst_func = INST_FUNC_BLT;
               3'd5:    d.inst_func = INST_FUNC_BGE;
               3'd6:    d.inst_func = INST_FUNC_BLTU;
               3'd7:    d.inst_func = INST_FUNC_BGEU;
               default: ill = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            d.inst_type     = INST_TYPE_I;
            d.reg1_raddr    = rs1;
            d.reg_waddr     = rd;
            d.reg_waddr_vld = 1'b1;
            d.imm           = imm_i;
            case (func3)
               3'd0:    d.inst_func = INST_FUNC_LB;
               3'd1:    d.inst_func = INST_FUNC_LH;
               3'd2:    d.inst_func = INST_FUNC_LW;
               3'd4:    d.inst_func = INST_FUNC_LBU;
               3'd5:    d.inst_func = INST_FUNC_LHU;
               default: ill = 1'b1;
            endcase
         end
         OPC_STORE: begin
            d.inst_type  = INST_TYPE_S;
            d.reg1_raddr = rs1;
            d.reg2_raddr = rs2;
            d.imm        = imm_s;
            case (func3)
               3'd0:    d.inst_func = INST_FUNC_SB;
               3'd1:    d.inst_func = INST_FUNC_SH;
               3'd2:    d.inst_func = INST_FUNC_SW;
               default: ill = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            d.inst_type     = INST_TYPE_I;
            d.reg1_raddr    = rs1;
            d.reg_waddr     = rd;
            d.reg_waddr_vld = 1'b1;
            d.imm           = imm_i;
            case (func3)
               3'd0: d.inst_func = INST_FUNC_ADDI;
               3'd2: d.inst_func = INST_FUNC_SLTI;
               3'd3: d.inst_func = INST_FUNC_SLTIU;
               3'd4: d.inst_func = INST_FUNC_XORI;
               3'd6: d.inst_func = INST_FUNC_ORI;
               3'd7: d.inst_func = INST_FUNC_ANDI;
               3'd1: begin
                  d.inst_func = INST_FUNC_SLLI;
                  ill         = (func7 != 7'b0000000);
               end
               default: begin
                  if (func7 == 7'b0000000)      d.inst_func = INST_FUNC_SRLI;
                  else if (func7 == 7'b0100000) d.inst_func = INST_FUNC_SRAI;
                  else                          ill = 1'b1;
               end
            endcase
         end
         OPC_OP: begin
            d.inst_type     = INST_TYPE_R;
            d.reg1_raddr    = rs1;
            d.reg2_raddr    = rs2;
            d.reg_waddr     = rd;
            d.reg_waddr_vld = 1'b1;
            if (func7 == 7'b0000000) begin
               case (func3)
                  3'd0:    d.inst_func = INST_FUNC_ADD;
                  3'd1:    d.inst_func = INST_FUNC_SLL;
                  3'd2:    d.inst_func = INST_FUNC_SLT;
                  3'd3:    d.inst_func = INST_FUNC_SLTU;
                  3'd4:    d.inst_func = INST_FUNC_XOR;
                  3'd5:    d.inst_func = INST_FUNC_SRL;
                  3'd6:    d.inst_func = INST_FUNC_OR;
                  default: d.inst_func = INST_FUNC_AND;
               endcase
            end else if (func7 == 7'b0100000 && func3 == 3'd0) begin
               d.inst_func = INST_FUNC_SUB;
            end else if (func7 == 7'b0100000 && func3 == 3'd5) begin
               d.inst_func = INST_FUNC_SRA;
`ifdef IDU_RV32M_EN
            end else if (func7[0] && func7[6:1] == 6'd0) begin
               d.inst_set = INST_SET_RV32M;
               case (func3)
                  3'd0:    d.inst_func = INST_FUNC_MUL;
                  3'd1:    d.inst_func = INST_FUNC_MULH;
                  3'd2:    d.inst_func = INST_FUNC_MULHSU;
                  3'd3:    d.inst_func = INST_FUNC_MULHU;
                  3'd4:    d.inst_func = INST_FUNC_DIV;
                  3'd5:    d.inst_func = INST_FUNC_DIVU;
                  3'd6:    d.inst_func = INST_FUNC_REM;
                  default: d.inst_func = INST_FUNC_REMU;
               endcase
`endif
            end else begin
               ill = 1'b1;
            end
         end
         OPC_MISC_MEM: begin
            d.inst_type = INST_TYPE_I;
            d.inst_func = INST_FUNC_FENCE;
            ill         = (func3 != 3'd0);
         end
         OPC_SYSTEM: begin
            d.inst_type = INST_TYPE_I;
            case (func3)
               3'd0: begin
                  // Privileged specials are matched on the full word.
                  case (inst_i)
                     32'h0000_0073: d.inst_func = INST_FUNC_ECALL;
                     32'h0010_0073: d.inst_func = INST_FUNC_EBREAK;
                     32'h3020_0073: d.inst_func = INST_FUNC_MRET;
                     32'h1050_0073: d.inst_func = INST_FUNC_WFI;
                     default:       ill = 1'b1;
                  endcase
               end
               3'd4: ill = 1'b1;
               default: begin
                  d.inst_set      = INST_SET_ZICSR;
                  d.inst_type     = INST_TYPE_CSR;
                  d.csr           = inst_i[31:20];
                  d.reg_waddr     = rd;
                  d.reg_waddr_vld = 1'b1;
                  if (func3[2]) d.imm        = {27'b0, rs1};
                  else          d.reg1_raddr = rs1;
                  case (func3)
                     3'd1:    d.inst_func = INST_FUNC_CSRRW;
                     3'd2:    d.inst_func = INST_FUNC_CSRRS;
                     3'd3:    d.inst_func = INST_FUNC_CSRRC;
                     3'd5:    d.inst_func = INST_FUNC_CSRRWI;
                     3'd6:    d.inst_func = INST_FUNC_CSRRSI;
                     default: d.inst_func = INST_FUNC_CSRRCI;
                  endcase
               end
            endcase
         end
         default: ill = 1'b1;
      endcase
      if (inst_i[1:0] != 2'b11) ill = 1'b1;
      if (ill) begin
         d         = '0;
         d.illegal = 1'b1;
      end
   end

   assign dec_o = d;

endmodule

// File: rtl/idu_queue.sv
// Instruction queue with a registered decode output stage; total capacity is DEPTH+1.
// The decoder variant is selected by IDU_RV32M_EN (see idu_dec).
module idu_queue
   import idu_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         flush_i,
   input  logic                         in_vld_i,
   output logic                         in_rdy_o,
   input  logic [DATA_BUS_WIDTH-1:0]    inst_i,
   input  logic [DATA_BUS_WIDTH-1:0]    pc_i,
   output logic                         out_vld_o,
   input  logic                         out_rdy_i,
   output logic [DATA_BUS_WIDTH-1:0]    pc_o,
   output logic [INST_SET_WIDTH-1:0]    inst_set_o,
   output logic [INST_TYPE_WIDTH-1:0]   inst_type_o,
   output logic [INST_FUNC_WIDTH-1:0]   inst_func_o,
   output logic [REG_BUS_WIDTH-1:0]     reg1_raddr_o,
   output logic [REG_BUS_WIDTH-1:0]     reg2_raddr_o,
   output logic [REG_BUS_WIDTH-1:0]     reg_waddr_o,
   output logic                         reg_waddr_vld_o,
   output logic [DATA_BUS_WIDTH-1:0]    imm_o,
   output logic [CSR_BUS_WIDTH-1:0]     csr_o,
   output logic                         illegal_o,
   output logic [$clog2(DEPTH+1)-1:0]   occ_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned OccW = $clog2(DEPTH + 1);

   logic [DATA_BUS_WIDTH-1:0] inst_mem [DEPTH];
   logic [DATA_BUS_WIDTH-1:0] pc_mem   [DEPTH];

   logic [PtrW-1:0] wptr_q, wptr_d;
   logic [PtrW-1:0] rptr_q, rptr_d;
   logic [OccW-1:0] occ_q, occ_d;
   logic            in_rdy_q;
   logic            out_vld_q, out_vld_d;
   logic [DATA_BUS_WIDTH-1:0] pc_q;
   dec_t            dec_q;

   logic push, q_empty, load_out, q_rd, bypass, q_wr, out_load;
   logic [DATA_BUS_WIDTH-1:0] sel_inst;
   logic [DATA_BUS_WIDTH-1:0] sel_pc;
   dec_t dec;

   assign push     = in_vld_i & in_rdy_q;
   assign q_empty  = (occ_q == '0);
   assign load_out = ~out_vld_q | out_rdy_i;
   assign q_rd     = load_out & ~q_empty;
   // With an empty queue the incoming instruction goes straight to the output stage.
   assign bypass   = load_out & q_empty & push;
   assign q_wr     = push & ~bypass;
   assign out_load = q_rd | bypass;

   assign sel_inst = q_empty ? inst_i : inst_mem[rptr_q];
   assign sel_pc   = q_empty ? pc_i   : pc_mem[rptr_q];

   idu_dec u_dec (
      .inst_i (sel_inst),
      .dec_o  (dec)
   );

   always_comb begin
      wptr_d    = wptr_q;
      rptr_d    = rptr_q;
      occ_d     = occ_q;
      out_vld_d = out_vld_q;
      if (flush_i) begin
         wptr_d    = '0;
         rptr_d    = '0;
         occ_d     = '0;
         out_vld_d = 1'b0;
      end else begin
         if (q_wr) wptr_d = wptr_q + PtrW'(1);
         if (q_rd) rptr_d = rptr_q + PtrW'(1);
         case ({q_wr, q_rd})
            2'b10:   occ_d = occ_q + OccW'(1);
            2'b01:   occ_d = occ_q - OccW'(1);
            default: occ_d = occ_q;
         endcase
         if (load_out) out_vld_d = out_load;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         occ_q     <= '0;
         in_rdy_q  <= 1'b1;
         out_vld_q <= 1'b0;
         pc_q      <= '0;
         dec_q     <= '0;
      end else begin
         wptr_q    <= wptr_d;
         rptr_q    <= rptr_d;
         occ_q     <= occ_d;
         in_rdy_q  <= (occ_d < OccW'(DEPTH));
         out_vld_q <= out_vld_d;
         if (out_load && !flush_i) begin
            pc_q  <= sel_pc;
            dec_q <= dec;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_n_i && q_wr && !flush_i) begin
         inst_mem[wptr_q] <= inst_i;
         pc_mem[wptr_q]   <= pc_i;
      end
   end

   assign in_rdy_o        = in_rdy_q;
   assign out_vld_o       = out_vld_q;
   assign occ_o           = occ_q;
   assign pc_o            = pc_q;
   assign inst_set_o      = dec_q.inst_set;
   assign inst_type_o     = dec_q.inst_type;
   assign inst_func_o     = dec_q.inst_func;
   assign reg1_raddr_o    = dec_q.reg1_raddr;
   assign reg2_raddr_o    = dec_q.reg2_raddr;
   assign reg_waddr_o     = dec_q.reg_waddr;
   assign reg_waddr_vld_o = dec_q.reg_waddr_vld;
   assign imm_o           = dec_q.imm;
   assign csr_o           = dec_q.csr;
   assign illegal_o       = dec_q.illegal;

endmodule
